// File: rtl/gen3_packet_tracker.sv
// gen3_packet_tracker: per-lane PCIe Gen3 framing tracker.
// Classifies each byte of a block stream and flags framing errors.
module gen3_packet_tracker #(
  parameter int         LANES     = 4,
  parameter logic [7:0] SDP_BYTE2 = 8'hAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [1:0]           sync_header,
  input  logic [8*LANES-1:0]   data_in,
  output logic [3*LANES-1:0]   byte_type,
  output logic [LANES-1:0]     pkt_start,
  output logic [LANES-1:0]     pkt_end,
  output logic                 framing_err
);

  typedef enum logic [2:0] {
    M_IDLE,
    M_STP_HDR,
    M_TLP,
    M_SDP_HDR,
    M_DLLP
  } mode_e;

  localparam logic [2:0] BT_IDLE = 3'd0;
  localparam logic [2:0] BT_STP  = 3'd1;
  localparam logic [2:0] BT_TLP  = 3'd2;
  localparam logic [2:0] BT_SDP  = 3'd3;
  localparam logic [2:0] BT_DLLP = 3'd4;
  localparam logic [2:0] BT_ERR  = 3'd7;

  mode_e              mode_q, mode_d;
  logic [1:0]         hdr_pos_q, hdr_pos_d;
  logic [11:0]        rem_q, rem_d;
  logic [3:0]         len_lo_q, len_lo_d;
  logic [3*LANES-1:0] byte_type_q, byte_type_d;
  logic [LANES-1:0]   pkt_start_q, pkt_start_d;
  logic [LANES-1:0]   pkt_end_q, pkt_end_d;
  logic               framing_err_q, framing_err_d;

  logic [7:0]         b;
  logic [10:0]        ldw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= M_IDLE;
      hdr_pos_q     <= '0;
      rem_q         <= '0;
      len_lo_q      <= '0;
      byte_type_q   <= '0;
      pkt_start_q   <= '0;
      pkt_end_q     <= '0;
      framing_err_q <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      hdr_pos_q     <= hdr_pos_d;
      rem_q         <= rem_d;
      len_lo_q      <= len_lo_d;
      byte_type_q   <= byte_type_d;
      pkt_start_q   <= pkt_start_d;
      pkt_end_q     <= pkt_end_d;
      framing_err_q <= framing_err_d;
    end
  end

  // Lanes are chained: each lane updates the *_d state the next one reads.
  always_comb begin
    mode_d        = mode_q;
    hdr_pos_d     = hdr_pos_q;
    rem_d         = rem_q;
    len_lo_d      = len_lo_q;
    byte_type_d   = '0;
    pkt_start_d   = '0;
    pkt_end_d     = '0;
    framing_err_d = 1'b0;
    b             = '0;
    ldw           = '0;
    if (valid) begin
      if (sync_header != 2'b01) begin
        if (mode_q != M_IDLE) begin
          framing_err_d = 1'b1;
          mode_d        = M_IDLE;
          rem_d         = '0;
          hdr_pos_d     = '0;
        end
      end else begin
        for (int k = 0; k < LANES; k++) begin
          b = data_in[8*k +: 8];
          unique case (mode_d)
            M_IDLE: begin
              unique case (1'b1)
                (b == 8'h00): begin
                end
                (b[3:0] == 4'hF): begin
                  byte_type_d[3*k +: 3] = BT_STP;
                  pkt_start_d[k]        = 1'b1;
                  len_lo_d              = b[7:4];
                  hdr_pos_d             = 2'd1;
                  mode_d                = M_STP_HDR;
                end
                (b == 8'hF0): begin
                  byte_type_d[3*k +: 3] = BT_SDP;
                  pkt_start_d[k]        = 1'b1;
                  hdr_pos_d             = 2'd1;
                  mode_d                = M_SDP_HDR;
                end
                default: begin
                  byte_type_d[3*k +: 3] = BT_ERR;
                  framing_err_d         = 1'b1;
                end
              endcase
            end
            M_STP_HDR: begin
              ldw       = {b[6:0], len_lo_d};
              hdr_pos_d = '0;
              if (ldw < 11'd2 || hdr_pos_d != 2'd0) begin
                byte_type_d[3*k +: 3] = BT_ERR;
                framing_err_d         = 1'b1;
                mode_d                = M_IDLE;
              end else begin
                byte_type_d[3*k +: 3] = BT_STP;
                rem_d                 = {ldw[9:0], 2'b00} - 12'd2;
                mode_d                = M_TLP;
              end
            end
            M_SDP_HDR: begin
              hdr_pos_d = '0;
              if (b == SDP_BYTE2) begin
                byte_type_d[3*k +: 3] = BT_SDP;
                rem_d                 = 12'd6;
                mode_d                = M_DLLP;
              end else begin
                byte_type_d[3*k +: 3] = BT_ERR;
                framing_err_d         = 1'b1;
                mode_d                = M_IDLE;
              end
            end
            M_TLP, M_DLLP: begin
              byte_type_d[3*k +: 3] = (mode_d == M_TLP) ? BT_TLP : BT_DLLP;
              if (rem_d == 12'd1) begin
                pkt_end_d[k] = 1'b1;
                mode_d       = M_IDLE;
              end
              rem_d = (rem_d == 12'd0) ? 12'd0 : rem_d - 12'd1;
            end
            default: begin
              mode_d = M_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign byte_type   = byte_type_q;
  assign pkt_start   = pkt_start_q;
  assign pkt_end     = pkt_end_q;
  assign framing_err = framing_err_q;

endmodule

// File: tb/tb_gen3_packet_tracker.sv
// Testbench for gen3_packet_tracker: byte-serial reference model feeding
// a scoreboard queue, plus directed spot checks per scenario.
module tb_gen3_packet_tracker;

  localparam int L = 4;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic           valid = 1'b0;
  logic [1:0]     sh    = 2'b01;
  logic [8*L-1:0] din   = '0;
  logic [3*L-1:0] bt;
  logic [L-1:0]   ps;
  logic [L-1:0]   pe;
  logic           fe;

  always #5 clk = ~clk;

  gen3_packet_tracker #(
    .LANES(L),
    .SDP_BYTE2(8'hAC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .sync_header(sh),
    .data_in(din),
    .byte_type(bt),
    .pkt_start(ps),
    .pkt_end(pe),
    .framing_err(fe)
  );

  typedef struct packed {
    logic [3*L-1:0] bt;
    logic [L-1:0]   ps;
    logic [L-1:0]   pe;
    logic           fe;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   m_mode = 0;
  int   m_rem  = 0;
  int   m_len  = 0;

  // Modes: 0 idle, 1 stp hdr, 2 tlp, 3 sdp hdr, 4 dllp
  task automatic model(input logic v, input logic [1:0] s,
                       input logic [8*L-1:0] d, output exp_t e);
    logic [7:0] by;
    int ldw;
    e = '0;
    if (v) begin
      if (s != 2'b01) begin
        if (m_mode != 0) begin
          e.fe = 1'b1; m_mode = 0; m_rem = 0;
        end
      end else begin
        for (int k = 0; k < L; k++) begin
          by = d[8*k +: 8];
          if (m_mode == 0) begin
            if (by == 8'h00) begin
            end else if (by[3:0] == 4'hF) begin
              e.bt[3*k +: 3] = 3'd1; e.ps[k] = 1'b1;
              m_len = int'(by[7:4]); m_mode = 1;
            end else if (by == 8'hF0) begin
              e.bt[3*k +: 3] = 3'd3; e.ps[k] = 1'b1; m_mode = 3;
            end else begin
              e.bt[3*k +: 3] = 3'd7; e.fe = 1'b1;
            end
          end else if (m_mode == 1) begin
            ldw = int'(by[6:0]) * 16 + m_len;
            if (ldw < 2) begin
              e.bt[3*k +: 3] = 3'd7; e.fe = 1'b1; m_mode = 0;
            end else begin
              e.bt[3*k +: 3] = 3'd1;
              m_rem = (4 * ldw - 2) % 4096; m_mode = 2;
            end
          end else if (m_mode == 3) begin
            if (by == 8'hAC) begin
              e.bt[3*k +: 3] = 3'd3; m_rem = 6; m_mode = 4;
            end else begin
              e.bt[3*k +: 3] = 3'd7; e.fe = 1'b1; m_mode = 0;
            end
          end else begin
            e.bt[3*k +: 3] = (m_mode == 2) ? 3'd2 : 3'd4;
            if (m_rem == 1) begin
              e.pe[k] = 1'b1; m_mode = 0;
            end
            if (m_rem > 0) m_rem = m_rem - 1;
          end
        end
      end
    end
  endtask

  task automatic beat(input logic v, input logic [1:0] s,
                      input logic [8*L-1:0] d);
    exp_t e;
    @(negedge clk);
    valid = v; sh = s; din = d;
    model(v, s, d, e);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      if (bt !== mon_e.bt)
        $display("FAIL sb byte_type: got %h expected %h", bt, mon_e.bt);
      else passes++;
      checks++;
      if (ps !== mon_e.ps)
        $display("FAIL sb pkt_start: got %b expected %b", ps, mon_e.ps);
      else passes++;
      checks++;
      if (pe !== mon_e.pe)
        $display("FAIL sb pkt_end: got %b expected %b", pe, mon_e.pe);
      else passes++;
      checks++;
      if (fe !== mon_e.fe)
        $display("FAIL sb framing_err: got %b expected %b", fe, mon_e.fe);
      else passes++;
    end
  end

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0;
    #12;
    checks++;
    if ({bt, ps, pe, fe} !== '0)
      $display("FAIL reset outputs: got %h expected 0", {bt, ps, pe, fe});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_long_tlp;
    int end_idx = -1;
    beat(1'b1, 2'b01, 32'h0000018F);
    checks++;
    if (bt !== 12'h489 || ps !== 4'b0001)
      $display("FAIL long start: got %h/%b expected 489/0001", bt, ps);
    else passes++;
    for (int i = 1; i < 24; i++) begin
      beat(1'b1, 2'b01, 32'hCAFECAFE);
      if (pe != '0 && end_idx < 0) end_idx = i;
      if (i == 23) begin
        checks++;
        if (pe !== 4'b1000)
          $display("FAIL long end lane: got %b expected 1000", pe);
        else passes++;
      end
    end
    checks++;
    if (end_idx != 23)
      $display("FAIL long end beat: got %0d expected 23", end_idx);
    else passes++;
  endtask

  task automatic test_split_token;
    beat(1'b1, 2'b01, 32'h2F000000);
    checks++;
    if (bt !== 12'h200 || ps !== 4'b1000)
      $display("FAIL split start: got %h/%b expected 200/1000", bt, ps);
    else passes++;
    beat(1'b1, 2'b01, 32'h11223300);
    checks++;
    if (bt !== 12'h491 || ps !== 4'b0000)
      $display("FAIL split hdr: got %h/%b expected 491/0000", bt, ps);
    else passes++;
    beat(1'b1, 2'b01, 32'h00556677);
    checks++;
    if (bt !== 12'h092 || pe !== 4'b0100)
      $display("FAIL split end: got %h/%b expected 092/0100", bt, pe);
    else passes++;
  endtask

  task automatic test_dllp;
    beat(1'b1, 2'b01, 32'h0201ACF0);
    checks++;
    if (bt !== 12'h91B || ps !== 4'b0001)
      $display("FAIL dllp start: got %h/%b expected 91b/0001", bt, ps);
    else passes++;
    beat(1'b1, 2'b01, 32'h06050403);
    checks++;
    if (pe !== 4'b1000)
      $display("FAIL dllp end: got %b expected 1000", pe);
    else passes++;
    beat(1'b1, 2'b01, 32'h0000001F);
    checks++;
    if (bt !== 12'h039 || ps !== 4'b0001 || fe !== 1'b1)
      $display("FAIL dllp next: got %h/%b/%b expected 039/0001/1",
               bt, ps, fe);
    else passes++;
  endtask

  task automatic test_error_recovery;
    beat(1'b1, 2'b01, 32'hACF05500);
    checks++;
    if (bt !== 12'h6F8 || ps !== 4'b0100 || fe !== 1'b1)
      $display("FAIL err lane: got %h/%b/%b expected 6f8/0100/1",
               bt, ps, fe);
    else passes++;
    beat(1'b1, 2'b01, 32'h04030201);
    checks++;
    if (fe !== 1'b0)
      $display("FAIL err pulse: got %b expected 0", fe);
    else passes++;
    beat(1'b1, 2'b01, 32'h00000605);
    checks++;
    if (pe !== 4'b0010)
      $display("FAIL err dllp end: got %b expected 0010", pe);
    else passes++;
  endtask

  task automatic test_ordered_set;
    beat(1'b1, 2'b01, 32'h0000028F);
    beat(1'b1, 2'b10, 32'h8F8F8F8F);
    checks++;
    if (bt !== 12'h000 || fe !== 1'b1)
      $display("FAIL os abort: got %h/%b expected 000/1", bt, fe);
    else passes++;
    beat(1'b1, 2'b01, 32'h0000018F);
    checks++;
    if (ps !== 4'b0001 || fe !== 1'b0)
      $display("FAIL os restart: got %b/%b expected 0001/0", ps, fe);
    else passes++;
    beat(1'b0, 2'b01, 32'h55555555);
    checks++;
    if ({bt, ps, pe, fe} !== '0)
      $display("FAIL hold outputs: got %h expected 0", {bt, ps, pe, fe});
    else passes++;
    beat(1'b1, 2'b01, 32'hCAFECAFE);
    checks++;
    if (bt !== 12'h492)
      $display("FAIL hold state: got %h expected 492", bt);
    else passes++;
    beat(1'b1, 2'b10, 32'h00000000);
    beat(1'b1, 2'b11, 32'h00000000);
    checks++;
    if (fe !== 1'b0)
      $display("FAIL os idle: got %b expected 0", fe);
    else passes++;
  endtask

  task automatic test_reset_mid;
    beat(1'b1, 2'b01, 32'h0201ACF0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bt, ps, pe, fe} !== '0)
      $display("FAIL async reset: got %h expected 0", {bt, ps, pe, fe});
    else passes++;
    m_mode = 0; m_rem = 0; m_len = 0;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    beat(1'b1, 2'b01, 32'h00000000);
    checks++;
    if ({bt, ps, pe, fe} !== '0)
      $display("FAIL post reset: got %h expected 0", {bt, ps, pe, fe});
    else passes++;
    beat(1'b1, 2'b01, 32'h00000000);
  endtask

  task automatic test_random;
    logic [7:0] tbl [10];
    logic [8*L-1:0] d;
    logic v;
    logic [1:0] s;
    tbl = '{8'h00, 8'hF0, 8'hAC, 8'h8F, 8'h01, 8'h2F,
            8'h1F, 8'h55, 8'h00, 8'h00};
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < L; k++) begin
        if ($urandom_range(0, 7) == 0) d[8*k +: 8] = 8'($urandom);
        else d[8*k +: 8] = tbl[$urandom_range(0, 9)];
      end
      v = ($urandom_range(0, 7) != 0);
      s = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b01;
      beat(v, s, d);
    end
  endtask

  initial begin
    test_reset;
    test_long_tlp;
    test_split_token;
    test_dllp;
    test_error_recovery;
    test_ordered_set;
    test_reset_mid;
    test_random;
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (q.size() != 0)
      $display("FAIL scoreboard drain: got %0d expected 0", q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
